output_ctrl: RTL and testbench

//  Router output port stage, directly downstream of the per-port input controllers.

---
 rtl/output_ctrl.sv | 127 ++++++++++++
 tb/tb_output_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/output_ctrl.sv
// Router output port: round-robin arbitration into even/odd VC buffers and link-side send handshake.
// Optional sent-flit counter built only when OUTPUT_CTRL_STATS_EN is defined.
//
// state  | meaning
// IDLE   | after reset, no grant and no send
// ODD    | write odd VC from inputs, send even VC to link
// EVEN   | write even VC from inputs, send odd VC to link
module output_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_IN     = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN-1:0]            sig_req_channel,
   input  logic [NUM_IN*DATA_WIDTH-1:0] inner_dataI,
   output logic [NUM_IN-1:0]            sig_channel_clean,
   input  logic                         receiveO,
   output logic                         sendO,
   output logic [DATA_WIDTH-1:0]        dataO,
   output logic                         polarity,
   output logic [CNT_WIDTH-1:0]         pkt_cnt
);

   localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [PTR_W:0]   NUM_IN_W = (PTR_W+1)'(NUM_IN);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_IN - 1);

   typedef enum logic [1:0] {S_IDLE, S_ODD, S_EVEN} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             vc_full;
   logic [DATA_WIDTH-1:0]  vc_data [2];
   logic [PTR_W-1:0]       rr_ptr  [2];

   logic                   active, p, q;
   logic                   win_found, grant, send;
   logic [PTR_W-1:0]       win_idx, ptr_nxt;
   logic [DATA_WIDTH-1:0]  win_data;

   // VC index 1 is the odd buffer, 0 the even one
   assign active = (state != S_IDLE);
   assign p      = (state == S_ODD);
   assign q      = ~p;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:  state_nxt = S_ODD;
         S_ODD:   state_nxt = S_EVEN;
         S_EVEN:  state_nxt = S_ODD;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      logic [PTR_W:0] sum;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         sum = {1'b0, rr_ptr[p]} + (PTR_W+1)'(k);
         if (sum >= NUM_IN_W) sum = sum - NUM_IN_W;
         if (!win_found && sig_req_channel[sum[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = sum[PTR_W-1:0];
         end
      end
   end

   assign win_data = inner_dataI[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign ptr_nxt  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

   // grant never looks at receiveO, so there is no comb path from the link to the inputs
   always_comb begin
      grant             = 1'b0;
      send              = 1'b0;
      sig_channel_clean = '0;
      dataO             = '0;
      polarity          = 1'b0;
      if (!rst) begin
         polarity = (state == S_ODD);
         grant    = active && !vc_full[p] && win_found;
         send     = active && vc_full[q] && receiveO;
         if (grant) sig_channel_clean[win_idx] = 1'b1;
         if (send)  dataO = vc_data[q];
      end
   end

   assign sendO = send;

   always_ff @(posedge clk) begin
      if (rst) begin
         vc_full <= '0;
         for (int i = 0; i < 2; i++) begin
            vc_data[i] <= '0;
            rr_ptr[i]  <= '0;
         end
      end else begin
         if (grant) begin
            vc_full[p] <= 1'b1;
            vc_data[p] <= win_data;
            rr_ptr[p]  <= ptr_nxt;
         end
         if (send) vc_full[q] <= 1'b0;
      end
   end

`ifdef OUTPUT_CTRL_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)                       cnt_q <= '0;
      else if (send && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
   end

   assign pkt_cnt = rst ? '0 : cnt_q;
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_output_ctrl.sv
// Directed bench for output_ctrl: reset, single flit, round-robin, backpressure,
// mid-flight reset and the optional sent-flit counter.
module tb_output_ctrl;

   localparam int DW = 64;
   localparam int NI = 4;
   localparam int CW = 4;
`ifdef OUTPUT_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [NI-1:0]    req;
   logic [NI*DW-1:0] din;
   logic [NI-1:0]    clean;
   logic             recv;
   logic             send;
   logic [DW-1:0]    dout;
   logic             pol;
   logic [CW-1:0]    cnt;

   int n_cmp = 0;
   int n_bad = 0;

   output_ctrl #(.DATA_WIDTH(DW), .NUM_IN(NI), .CNT_WIDTH(CW)) dut (
      .clk               (clk),
      .rst               (rst),
      .sig_req_channel   (req),
      .inner_dataI       (din),
      .sig_channel_clean (clean),
      .receiveO          (recv),
      .sendO             (send),
      .dataO             (dout),
      .polarity          (pol),
      .pkt_cnt           (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] dpat(input int i);
      return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0101;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with every input high
      rst = 1'b1; req = '1; recv = 1'b1; din = '1;
      #1;
      chk("rst_send", 64'(send), 0);
      chk("rst_clean", 64'(clean), 0);
      chk("rst_pol", 64'(pol), 0);
      chk("rst_data", dout, 0);
      next_cycle(); #1;
      chk("rst_send2", 64'(send), 0);
      chk("rst_cnt", 64'(cnt), 0);
      next_cycle();
      rst = 1'b0; req = '0; din = '0;
      #1;
      chk("idle_pol", 64'(pol), 0);
      chk("idle_clean", 64'(clean), 0);
      chk("idle_send", 64'(send), 0);

      // single flit through input 2
      next_cycle();
      req = 4'b0100; din[2*DW +: DW] = 64'hA5A5_0000_0000_0001;
      #1;
      chk("sf_pol", 64'(pol), 1);
      chk("sf_grant", 64'(clean), 64'b0100);
      chk("sf_nosend", 64'(send), 0);
      next_cycle();
      req = '0;
      #1;
      chk("sf_pol_even", 64'(pol), 0);
      chk("sf_send", 64'(send), 1);
      chk("sf_data", dout, 64'hA5A5_0000_0000_0001);
      chk("sf_clean0", 64'(clean), 0);
      next_cycle(); #1;
      chk("sf_drained", 64'(send), 0);
      chk("sf_data0", dout, 0);

      // round-robin from fresh pointers
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; req = '1;
      for (int i = 0; i < NI; i++) din[i*DW +: DW] = dpat(i);
      #1;
      chk("rr_idle_clean", 64'(clean), 0);
      for (int k = 0; k < 5; k++) begin
         next_cycle(); #1;
         chk($sformatf("rr_odd_grant%0d", k), 64'(clean), 64'(1 << (k % 4)));
         chk($sformatf("rr_odd_send%0d", k), 64'(send), (k > 0) ? 64'd1 : 64'd0);
         chk($sformatf("rr_odd_data%0d", k), dout, (k > 0) ? dpat((k + 3) % 4) : 64'd0);
         next_cycle(); #1;
         chk($sformatf("rr_even_grant%0d", k), 64'(clean), 64'(1 << (k % 4)));
         chk($sformatf("rr_even_send%0d", k), 64'(send), 1);
         chk($sformatf("rr_even_data%0d", k), dout, dpat(k % 4));
      end

      // backpressure: even VC holds dpat(0), pointers odd=1 even=1
      next_cycle();
      recv = 1'b0;
      #1;
      chk("bp_odd_grant", 64'(clean), 64'b0010);
      chk("bp_odd_send", 64'(send), 0);
      chk("bp_odd_data", dout, 0);
      next_cycle(); #1;
      chk("bp_even_clean", 64'(clean), 0);
      chk("bp_even_send", 64'(send), 0);
      next_cycle(); #1;
      chk("bp_odd2_clean", 64'(clean), 0);
      chk("bp_odd2_send", 64'(send), 0);
      next_cycle(); #1;
      chk("bp_even2_clean", 64'(clean), 0);
      next_cycle();
      recv = 1'b1;
      #1;
      chk("bp_rel_clean", 64'(clean), 0);
      chk("bp_rel_send", 64'(send), 1);
      chk("bp_rel_data", dout, dpat(0));
      next_cycle(); #1;
      chk("bp_even_send3", 64'(send), 1);
      chk("bp_even_data3", dout, dpat(1));
      chk("bp_even_grant3", 64'(clean), 64'b0010);
      next_cycle(); #1;
      chk("bp_resume_grant", 64'(clean), 64'b0100);
      chk("bp_resume_data", dout, dpat(1));

      // fill both VCs, then reset mid-flight
      next_cycle();
      recv = 1'b0;
      #1;
      chk("mf_even_grant", 64'(clean), 64'b0100);
      chk("mf_even_send", 64'(send), 0);
      next_cycle();
      rst = 1'b1; recv = 1'b1;
      #1;
      chk("mf_rst_send", 64'(send), 0);
      chk("mf_rst_data", dout, 0);
      chk("mf_rst_clean", 64'(clean), 0);
      next_cycle();
      rst = 1'b0; req = '0;
      #1;
      chk("mf_idle_send", 64'(send), 0);
      chk("mf_idle_data", dout, 0);
      next_cycle(); #1;
      chk("mf_odd_send", 64'(send), 0);
      chk("mf_odd_data", dout, 0);
      chk("mf_odd_clean", 64'(clean), 0);
      next_cycle(); #1;
      chk("mf_even_send2", 64'(send), 0);
      chk("mf_even_data2", dout, 0);

      // sent-flit counter: one send per cycle from the first EVEN cycle on
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; req = '1; recv = 1'b1;
      for (int c = 0; c < 24; c++) begin
         int sent;
         #1;
         sent = (c > 2) ? c - 2 : 0;
         chk($sformatf("cnt_c%0d", c), 64'(cnt),
             STATS ? ((sent > 15) ? 64'd15 : 64'(sent)) : 64'd0);
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
